// File: rtl/pipe_share_arb.sv
// pipe_share_arb: two requesters share one registered inverting pipeline
// (stage 1 capture -> invert -> stage 2), round-robin arbitrated.
// A granted word comes out two cycles later on y, tagged with its requester ID.
// Optional feature macro: PSA_BURST_EN. When it is defined, a requester keeps
// priority for up to BURST consecutive contended grants.
module pipe_share_arb #(
  parameter int W     = 1,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rb,
  input  logic         en,
  input  logic         req0,
  input  logic [W-1:0] d0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [W-1:0] d1,
  output logic         gnt1,
  output logic [W-1:0] y,
  output logic         y_vld,
  output logic         y_id
);

  // BURST below 1 is not a legal setting; this block makes such a build visible
  // in the elaborated hierarchy.
  if (BURST < 1) begin : g_burst_illegal
  end

  logic         prio_r;
  logic         prio_nxt_s;
  logic         gnt0_s;
  logic         gnt1_s;
  logic         any_gnt_s;
  logic         contend_s;
  logic         s1_v_r;
  logic [W-1:0] s1_d_r;
  logic         s1_id_r;
  logic         s2_v_r;
  logic [W-1:0] s2_d_r;
  logic         s2_id_r;

  // Grant selection; grants are held low during reset and when arbitration is off.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rb && en) begin
      if (req0 && req1) begin
        if (prio_r) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else if (req0) begin
        gnt0_s = 1'b1;
      end else if (req1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign any_gnt_s = gnt0_s | gnt1_s;
  assign contend_s = req0 & req1;

`ifdef PSA_BURST_EN
  // Counter is wide enough to hold BURST itself.
  localparam int CW = (BURST > 1) ? $clog2(BURST + 1) : 1;
  localparam logic [CW:0] BURST_LIM = BURST[CW:0];

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [CW:0]   cnt_inc_s;
  logic          owner_req_s;

  assign cnt_inc_s   = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
  assign owner_req_s = prio_r ? req1 : req0;

  // Priority keeps the current owner until its contended run hits BURST or it
  // stops requesting; uncontended grants leave the run count alone.
  always_comb begin
    prio_nxt_s = prio_r;
    cnt_nxt_s  = cnt_r;
    if (any_gnt_s && contend_s) begin
      if (cnt_inc_s >= BURST_LIM) begin
        prio_nxt_s = ~gnt1_s;
        cnt_nxt_s  = {CW{1'b0}};
      end else begin
        prio_nxt_s = gnt1_s;
        cnt_nxt_s  = cnt_inc_s[CW-1:0];
      end
    end else if (!owner_req_s && (cnt_r != {CW{1'b0}})) begin
      prio_nxt_s = ~prio_r;
      cnt_nxt_s  = {CW{1'b0}};
    end else begin
      prio_nxt_s = prio_r;
      cnt_nxt_s  = cnt_r;
    end
  end

  // Burst run counter register.
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  // Strict alternation: every contended grant hands priority to the other side.
  always_comb begin
    prio_nxt_s = prio_r;
    if (any_gnt_s && contend_s) begin
      prio_nxt_s = ~gnt1_s;
    end else begin
      prio_nxt_s = prio_r;
    end
  end
`endif

  // Priority register; requester 0 is favoured out of reset.
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_nxt_s;
    end
  end

  // Stage 1 captures the granted word and its owner; data holds when idle.
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      s1_v_r  <= 1'b0;
      s1_d_r  <= {W{1'b0}};
      s1_id_r <= 1'b0;
    end else if (any_gnt_s) begin
      s1_v_r  <= 1'b1;
      s1_d_r  <= gnt1_s ? d1 : d0;
      s1_id_r <= gnt1_s;
    end else begin
      s1_v_r  <= 1'b0;
    end
  end

  // Stage 2 inverts and advances every cycle; there is no stall path.
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      s2_v_r  <= 1'b0;
      s2_d_r  <= {W{1'b0}};
      s2_id_r <= 1'b0;
    end else begin
      s2_v_r  <= s1_v_r;
      s2_d_r  <= ~s1_d_r;
      s2_id_r <= s1_id_r;
    end
  end

  assign y     = s2_d_r;
  assign y_vld = s2_v_r;
  assign y_id  = s2_id_r;

endmodule

// File: tb/tb_pipe_share_arb.sv
// Bench for pipe_share_arb: table of per-cycle stimulus with expected grants,
// a scoreboard queue of expected results checked when they are due on y, and
// hand-written reset sequences.
module tb_pipe_share_arb;

  localparam int W     = 4;
  localparam int BURST = 2;

  // Grant pattern for continuous contention starting from reset; bit i is the
  // grantee in cycle i.
`ifdef PSA_BURST_EN
  localparam logic [5:0] SEQ_BOTH = 6'b001100;
`else
  localparam logic [5:0] SEQ_BOTH = 6'b101010;
`endif

  logic         clk = 1'b0;
  logic         rb;
  logic         en;
  logic         req0;
  logic         req1;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] y;
  logic         y_vld;
  logic         y_id;

  pipe_share_arb #(.W(W), .BURST(BURST)) dut (
    .clk  (clk),
    .rb   (rb),
    .en   (en),
    .req0 (req0),
    .d0   (d0),
    .gnt0 (gnt0),
    .req1 (req1),
    .d1   (d1),
    .gnt1 (gnt1),
    .y    (y),
    .y_vld(y_vld),
    .y_id (y_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rst;
    logic         en;
    logic         r0;
    logic         r1;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         e0;
    logic         e1;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] y;
    logic         id;
    logic [31:0]  cyc;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[$];
  logic [31:0] cycle = 32'd0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cycle <= cycle + 32'd1;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic vec_t mk(input logic rs, input logic e, input logic r0, input logic r1,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic e0, input logic e1);
    vec_t v;
    v.rst = rs; v.en = e; v.r0 = r0; v.r1 = r1;
    v.a = a; v.b = b; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic push_exp(input logic [W-1:0] din, input logic id);
    exp_t e;
    e.y = ~din; e.id = id; e.cyc = cycle;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rb = 1'b0; en = 1'b0; req0 = 1'b0; req1 = 1'b0;
    sbq.delete();
    @(negedge clk);
    rb = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rst) do_reset();
    @(negedge clk);
    en = v.en; req0 = v.r0; req1 = v.r1; d0 = v.a; d1 = v.b;
    #2;
    check1($sformatf("vec%0d gnt0", idx), {31'd0, gnt0}, {31'd0, v.e0});
    check1($sformatf("vec%0d gnt1", idx), {31'd0, gnt1}, {31'd0, v.e1});
    if (v.e0) push_exp(v.a, 1'b0);
    if (v.e1) push_exp(v.b, 1'b1);
  endtask

  // Scoreboard: a result is due exactly two cycles after its grant, else y_vld must be low.
  always @(negedge clk) begin : monitor
    logic ev;
    exp_t e;
    ev = 1'b0;
    if (rb === 1'b1) begin
      ev = (sbq.size() > 0) ? (sbq[0].cyc + 32'd2 == cycle) : 1'b0;
      check1("y_vld", {31'd0, y_vld}, {31'd0, ev});
      if (ev) begin
        e = sbq.pop_front();
        check1("y", {28'd0, y}, {28'd0, e.y});
        check1("y_id", {31'd0, y_id}, {31'd0, e.id});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [5:0] seq;
    seq = SEQ_BOTH;
    rb = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    #1 rb = 1'b0;

    // Reset holds grants low even with both requesting, then first cycle out grants req0.
    en = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = 4'h5; d1 = 4'h9;
    repeat (2) @(negedge clk);
    #2;
    check1("rst gnt0", {31'd0, gnt0}, 32'd0);
    check1("rst gnt1", {31'd0, gnt1}, 32'd0);
    check1("rst y", {28'd0, y}, 32'd0);
    check1("rst y_vld", {31'd0, y_vld}, 32'd0);
    check1("rst y_id", {31'd0, y_id}, 32'd0);
    @(negedge clk);
    rb = 1'b1;
    #2;
    check1("first gnt0", {31'd0, gnt0}, 32'd1);
    check1("first gnt1", {31'd0, gnt1}, 32'd0);
    push_exp(4'h5, 1'b0);

    // Stimulus table
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
    // Single requester streaming 4'h3, then requester 1 alone, then idle.
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h6, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
    // Continuous contention for six cycles from reset.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk((i == 0), 1'b1, 1'b1, 1'b1, 4'(i + 1), 4'(4'hA + i), ~seq[i], seq[i]));
    // Arbitration disabled with requests pending.
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 4'h8, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));
    // en drops in cycle 3 of a contended stream; in-flight words still drain.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk((i == 0), (i < 3), 1'b1, 1'b1, 4'(4'hC + i), 4'(i * 3),
                       (i < 3) ? ~seq[i] : 1'b0, (i < 3) ? seq[i] : 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted mid-stream while a result is on y.
    apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, ~seq[0], seq[0]), 100);
    apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 4'h8, ~seq[1], seq[1]), 101);
    apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 4'hD, ~seq[2], seq[2]), 102);
    @(negedge clk);
    #1;
    rb = 1'b0;
    sbq.delete();
    #1;
    check1("midrst y_vld", {31'd0, y_vld}, 32'd0);
    check1("midrst y", {28'd0, y}, 32'd0);
    check1("midrst gnt0", {31'd0, gnt0}, 32'd0);
    check1("midrst gnt1", {31'd0, gnt1}, 32'd0);
    @(negedge clk);
    d0 = 4'hB; d1 = 4'h2;
    rb = 1'b1;
    #2;
    check1("post-rst gnt0", {31'd0, gnt0}, 32'd1);
    check1("post-rst gnt1", {31'd0, gnt1}, 32'd0);
    push_exp(4'hB, 1'b0);
    for (int i = 0; i < 4; i++)
      apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0), 200 + i);

    // Every expected result must have emerged.
    repeat (3) @(negedge clk);
    #1;
    check1("drain", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
